// File: rtl/mecanum_step_gen_if.sv
// Command handshake between the motion command decoder (master) and the step generator (slave).
interface mecanum_step_gen_if #(
    parameter int STEP_W = 16
);
    logic              ctl_valid;
    logic [1:0]        dx;
    logic [1:0]        dy;
    logic [1:0]        da;
    logic [STEP_W-1:0] ctl_ticks;
    logic              drv_ready;

    modport master (output ctl_valid, dx, dy, da, ctl_ticks, input drv_ready);
    modport slave  (input ctl_valid, dx, dy, da, ctl_ticks, output drv_ready);
endinterface

// File: rtl/mecanum_step_gen.sv
// Four-wheel mecanum stepper pulse generator with per-wheel DDA rate division.
// Optional MECANUM_STEP_HOLD_EN: keep drivers enabled (holding torque) after a normal move.
module mecanum_step_gen #(
    parameter int CLK_HZ      = 25000000,
    parameter int STEP_HZ     = 1000,
    parameter int STEP_NUMBER = 6000,
    parameter int STEP_W      = 16,
    parameter int SETUP_CYC   = 25,
    parameter int PULSE_CYC   = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    mecanum_step_gen_if.slave cmd,
    output logic [3:0]        nen,
    output logic [3:0]        dir,
    output logic [3:0]        step,
    output logic              done
);
    localparam int TICK_DIV = CLK_HZ / STEP_HZ;
    localparam int CNT_MAX  = (TICK_DIV > SETUP_CYC) ? TICK_DIV : SETUP_CYC;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int PW       = $clog2(PULSE_CYC + 1);

`ifdef MECANUM_STEP_HOLD_EN
    localparam logic [3:0] NEN_DONE = 4'h0;
`else
    localparam logic [3:0] NEN_DONE = 4'hF;
`endif

    // LOAD is the cycle after accept, where dir/nen are first driven
    typedef enum logic [2:0] {IDLE, LOAD, SETUP, RUN, FINISH} state_t;
    state_t state, state_nxt;

    function automatic logic signed [2:0] dec(input logic [1:0] c);
        case (c)
            2'b01:   dec = 3'sd1;
            2'b11:   dec = -3'sd1;
            default: dec = 3'sd0;
        endcase
    endfunction

    logic signed [2:0] ux, uy, ua;
    logic signed [2:0] v [4];
    logic [3:0][1:0]    mag_in, mag, acc;
    logic [3:0][2:0]    acc_sum;
    logic [3:0][PW-1:0] pcnt;
    logic [3:0]         fwd_in, fwd;
    logic [CW-1:0]      cnt;
    logic [STEP_W-1:0]  ticks, tk;
    logic               accept, tick_end, last_tick, abort;

    assign ux   = dec(cmd.dx);
    assign uy   = dec(cmd.dy);
    assign ua   = dec(cmd.da);
    assign v[0] = uy - ux - ua;
    assign v[1] = uy + ux + ua;
    assign v[2] = uy + ux - ua;
    assign v[3] = uy - ux + ua;

    for (genvar i = 0; i < 4; i++) begin : g_wheel
        assign fwd_in[i]  = ~v[i][2];
        assign mag_in[i]  = v[i][2] ? 2'(-v[i]) : v[i][1:0];
        assign acc_sum[i] = {1'b0, acc[i]} + {1'b0, mag[i]};
    end

    assign accept    = (state == IDLE) && cmd.drv_ready && cmd.ctl_valid;
    assign tick_end  = (state == RUN) && (cnt == CW'(TICK_DIV - 1));
    assign last_tick = tick_end && (tk == ticks - STEP_W'(1));
    assign abort     = !enable && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = (mag == '0) ? IDLE : SETUP;
            SETUP:   if (cnt == CW'(SETUP_CYC - 1)) state_nxt = RUN;
            RUN:     if (last_tick) state_nxt = FINISH;
            FINISH:  if (step == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nen           <= 4'hF;
            dir           <= '0;
            step          <= '0;
            done          <= 1'b0;
            cmd.drv_ready <= 1'b0;
            mag           <= '0;
            fwd           <= '0;
            acc           <= '0;
            pcnt          <= '0;
            cnt           <= '0;
            ticks         <= '0;
            tk            <= '0;
        end else begin
            done          <= 1'b0;
            cmd.drv_ready <= (state == IDLE) && enable;
            for (int i = 0; i < 4; i++) begin
                if (step[i]) begin
                    if (pcnt[i] == '0) step[i] <= 1'b0;
                    else               pcnt[i] <= pcnt[i] - PW'(1);
                end
            end
            case (state)
                IDLE: if (accept) begin
                    mag   <= mag_in;
                    fwd   <= fwd_in;
                    ticks <= (cmd.ctl_ticks == '0) ? STEP_W'(STEP_NUMBER) : cmd.ctl_ticks;
                    acc   <= '0;
                    cnt   <= '0;
                    tk    <= '0;
                end
                LOAD: begin
                    dir  <= fwd;
                    nen  <= (mag == '0) ? 4'hF : 4'h0;
                    done <= (mag == '0);
                end
                SETUP: cnt <= (cnt == CW'(SETUP_CYC - 1)) ? '0 : cnt + CW'(1);
                RUN: begin
                    cnt <= tick_end ? '0 : cnt + CW'(1);
                    if (tick_end) begin
                        tk <= tk + STEP_W'(1);
                        // DDA: a wheel steps whenever its accumulated speed crosses 3
                        for (int i = 0; i < 4; i++) begin
                            if (acc_sum[i] >= 3'd3) begin
                                acc[i]  <= 2'(acc_sum[i] - 3'd3);
                                step[i] <= 1'b1;
                                pcnt[i] <= PW'(PULSE_CYC - 1);
                            end else begin
                                acc[i]  <= acc_sum[i][1:0];
                            end
                        end
                    end
                end
                FINISH: if (step == '0) begin
                    done <= 1'b1;
                    nen  <= NEN_DONE;
                end
                default: ;
            endcase
            if (abort) begin
                step <= '0;
                nen  <= 4'hF;
                done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mecanum_step_gen.sv
// Directed bench for mecanum_step_gen: TICK_DIV=10, SETUP_CYC=2, PULSE_CYC=3, STEP_NUMBER=3.
module tb_mecanum_step_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] nen, dir, step;
    logic       done;

    mecanum_step_gen_if #(.STEP_W(16)) bus();

    mecanum_step_gen #(
        .CLK_HZ(1000), .STEP_HZ(100), .STEP_NUMBER(3), .STEP_W(16),
        .SETUP_CYC(2), .PULSE_CYC(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cmd(bus),
        .nen(nen), .dir(dir), .step(step), .done(done)
    );

    always #5 clk = ~clk;

`ifdef MECANUM_STEP_HOLD_EN
    localparam logic [3:0] NEN_END = 4'h0;
`else
    localparam logic [3:0] NEN_END = 4'hF;
`endif

    int n_chk = 0, n_pass = 0;
    int cyc = 0, done_cnt = 0;
    int step_cnt [4] = '{default: 0};
    logic [3:0] step_q = '0;

    // Counts edges and step rising edges, sampled 1 time unit after each clock edge
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) if (step[i] && !step_q[i]) step_cnt[i]++;
        step_q = step;
        if (done) done_cnt++;
    end

    task automatic send_cmd(input logic [1:0] x, y, a, input logic [15:0] t, output int t_acc);
        int k = 0;
        while (bus.drv_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        n_chk++;
        if (bus.drv_ready !== 1'b1) $display("FAIL ready_timeout: drv_ready=%b want 1", bus.drv_ready);
        else n_pass++;
        bus.dx = x; bus.dy = y; bus.da = a; bus.ctl_ticks = t; bus.ctl_valid = 1'b1;
        @(negedge clk);
        bus.ctl_valid = 1'b0;
        t_acc = cyc;
    endtask

    task automatic wait_done(input int bound, output int t_done);
        int k = 0;
        while (done !== 1'b1 && k < bound) begin @(negedge clk); k++; end
        t_done = cyc;
        n_chk++;
        if (done !== 1'b1) $display("FAIL done_timeout: done=%b want 1", done);
        else n_pass++;
    endtask

    task automatic test_reset;
        n_chk++; if (nen !== 4'hF) $display("FAIL rst_nen: got %h want F", nen); else n_pass++;
        n_chk++; if (dir !== 4'h0) $display("FAIL rst_dir: got %h want 0", dir); else n_pass++;
        n_chk++; if (step !== 4'h0) $display("FAIL rst_step: got %h want 0", step); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_chk++; if (bus.drv_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.drv_ready); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.drv_ready !== 1'b0) $display("FAIL ready_no_enable: got %b want 0", bus.drv_ready); else n_pass++;
        enable = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.drv_ready !== 1'b1) $display("FAIL ready_enable: got %b want 1", bus.drv_ready); else n_pass++;
    endtask

    task automatic test_forward;
        int ta, td, d0;
        int s0 [4];
        int ex [4] = '{2, 2, 2, 2};
        s0 = step_cnt; d0 = done_cnt;
        send_cmd(2'b00, 2'b01, 2'b00, 16'd6, ta);
        n_chk++; if (nen !== 4'hF) $display("FAIL fwd_nen_at_accept: got %h want F", nen); else n_pass++;
        n_chk++; if (bus.drv_ready !== 1'b1) $display("FAIL fwd_ready_lag: got %b want 1", bus.drv_ready); else n_pass++;
        @(negedge clk);
        n_chk++; if (nen !== 4'h0) $display("FAIL fwd_nen_on: got %h want 0", nen); else n_pass++;
        n_chk++; if (dir !== 4'hF) $display("FAIL fwd_dir: got %h want F", dir); else n_pass++;
        n_chk++; if (bus.drv_ready !== 1'b0) $display("FAIL fwd_ready_busy: got %b want 0", bus.drv_ready); else n_pass++;
        wait_done(200, td);
        n_chk++; if (td - ta != 67) $display("FAIL fwd_done_latency: got %0d want 67", td - ta); else n_pass++;
        n_chk++; if (nen !== NEN_END) $display("FAIL fwd_nen_end: got %h want %h", nen, NEN_END); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (step_cnt[i] - s0[i] != ex[i]) $display("FAIL fwd_steps_w%0d: got %0d want %0d", i, step_cnt[i] - s0[i], ex[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++; if (bus.drv_ready !== 1'b1) $display("FAIL fwd_ready_after: got %b want 1", bus.drv_ready); else n_pass++;
        n_chk++; if (done_cnt - d0 != 1) $display("FAIL fwd_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_mixed;
        int ta, td;
        int s0 [4];
        int ex [4] = '{2, 6, 2, 2};
        s0 = step_cnt;
        send_cmd(2'b01, 2'b01, 2'b01, 16'd6, ta);
        @(negedge clk);
        n_chk++; if (dir !== 4'hE) $display("FAIL mix_dir: got %h want E", dir); else n_pass++;
        wait_done(200, td);
        n_chk++; if (td - ta != 67) $display("FAIL mix_done_latency: got %0d want 67", td - ta); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (step_cnt[i] - s0[i] != ex[i]) $display("FAIL mix_steps_w%0d: got %0d want %0d", i, step_cnt[i] - s0[i], ex[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_default_len;
        int ta, td;
        int s0 [4];
        int ex [4] = '{0, 2, 2, 0};
        s0 = step_cnt;
        send_cmd(2'b01, 2'b01, 2'b00, 16'd0, ta);
        @(negedge clk);
        n_chk++; if (dir !== 4'hF) $display("FAIL dflt_dir: got %h want F", dir); else n_pass++;
        n_chk++; if (nen !== 4'h0) $display("FAIL dflt_nen: got %h want 0", nen); else n_pass++;
        wait_done(200, td);
        n_chk++; if (td - ta != 37) $display("FAIL dflt_done_latency: got %0d want 37", td - ta); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (step_cnt[i] - s0[i] != ex[i]) $display("FAIL dflt_steps_w%0d: got %0d want %0d", i, step_cnt[i] - s0[i], ex[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_zero;
        int ta;
        int s0 [4];
        s0 = step_cnt;
        send_cmd(2'b00, 2'b10, 2'b00, 16'd5, ta);
        @(negedge clk);
        n_chk++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
        n_chk++; if (nen !== 4'hF) $display("FAIL zero_nen: got %h want F", nen); else n_pass++;
        @(negedge clk);
        n_chk++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done); else n_pass++;
        n_chk++; if (bus.drv_ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", bus.drv_ready); else n_pass++;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (step_cnt[i] != s0[i]) $display("FAIL zero_steps_w%0d: got %0d want 0", i, step_cnt[i] - s0[i]);
            else n_pass++;
        end
    endtask

    task automatic test_abort;
        int ta, d0, k;
        d0 = done_cnt; k = 0;
        send_cmd(2'b00, 2'b01, 2'b00, 16'd6, ta);
        while (step === 4'h0 && k < 100) begin @(negedge clk); k++; end
        n_chk++; if (step !== 4'hF) $display("FAIL abort_pulse_seen: got %h want F", step); else n_pass++;
        enable = 1'b0;
        @(negedge clk);
        n_chk++; if (step !== 4'h0) $display("FAIL abort_step: got %h want 0", step); else n_pass++;
        n_chk++; if (nen !== 4'hF) $display("FAIL abort_nen: got %h want F", nen); else n_pass++;
        repeat (5) @(negedge clk);
        n_chk++; if (done_cnt != d0) $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); else n_pass++;
        n_chk++; if (bus.drv_ready !== 1'b0) $display("FAIL abort_ready_low: got %b want 0", bus.drv_ready); else n_pass++;
        enable = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.drv_ready !== 1'b1) $display("FAIL abort_ready_back: got %b want 1", bus.drv_ready); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int td, d0;
        int s0 [4];
        s0 = step_cnt; d0 = done_cnt;
        bus.dx = 2'b00; bus.dy = 2'b01; bus.da = 2'b00; bus.ctl_ticks = 16'd3; bus.ctl_valid = 1'b1;
        @(negedge clk);
        wait_done(200, td);
        bus.ctl_valid = 1'b0;
        n_chk++; if (nen !== NEN_END) $display("FAIL b2b_nen_end: got %h want %h", nen, NEN_END); else n_pass++;
        repeat (20) @(negedge clk);
        n_chk++; if (done_cnt - d0 != 1) $display("FAIL b2b_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
        n_chk++; if (nen !== NEN_END) $display("FAIL b2b_nen_stay: got %h want %h", nen, NEN_END); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (step_cnt[i] - s0[i] != 1) $display("FAIL b2b_steps_w%0d: got %0d want 1", i, step_cnt[i] - s0[i]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        int ta;
        send_cmd(2'b00, 2'b01, 2'b00, 16'd6, ta);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (nen !== 4'hF) $display("FAIL arst_nen: got %h want F", nen); else n_pass++;
        n_chk++; if (dir !== 4'h0) $display("FAIL arst_dir: got %h want 0", dir); else n_pass++;
        n_chk++; if (bus.drv_ready !== 1'b0) $display("FAIL arst_ready: got %b want 0", bus.drv_ready); else n_pass++;
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.ctl_valid = 1'b0; bus.dx = '0; bus.dy = '0; bus.da = '0; bus.ctl_ticks = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_forward();
        test_mixed();
        test_default_len();
        test_zero();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
